// File: rtl/ext_unit_pipe_if.sv
// Handshake bundle for the extension unit: input side (valid/ready, field,
// mode, tag), output side (valid/ready, word, tag) and buffer occupancy.
interface ext_unit_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;

    // master: decode side producing operands and ID/EX side consuming them
    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, occupancy
    );

    // slave: the extension unit itself
    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, occupancy
    );
endinterface

// File: rtl/ext_unit_pipe.sv
// Registered immediate extension unit (SEXT/ZEXT/UPPER/SEXT_SHL2) feeding a
// 2-entry output FIFO. Ports: Clk, Reset (sync, high), flush, bus (slave).
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            flush,
    ext_unit_pipe_if.slave  bus
);

    localparam int PAD_W = OUT_W - IN_W;

    generate
        if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_width
            $error("ext_unit_pipe: need 2 <= IN_W < OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        M_SEXT  = 2'd0,
        M_ZEXT  = 2'd1,
        M_UPPER = 2'd2,
        M_SHL2  = 2'd3
    } mode_e;

    // ---------------------------------------------------------------
    // Extension datapath
    // ---------------------------------------------------------------
    logic [OUT_W-1:0] sext_w;
    logic [OUT_W-1:0] zext_w;
    logic [OUT_W-1:0] upper_w;
    logic [OUT_W-1:0] shl2_w;
    logic [OUT_W-1:0] ext_w;

    assign sext_w  = {{PAD_W{bus.in_data[IN_W-1]}}, bus.in_data};
    assign zext_w  = {{PAD_W{1'b0}}, bus.in_data};
    assign upper_w = {bus.in_data, {PAD_W{1'b0}}};
    // branch offset: top two sign bits fall off the word
    assign shl2_w  = {sext_w[OUT_W-3:0], 2'b00};

    always_comb begin
        ext_w = sext_w;
        unique case (mode_e'(bus.in_mode))
            M_SEXT:  ext_w = sext_w;
            M_ZEXT:  ext_w = zext_w;
            M_UPPER: ext_w = upper_w;
            M_SHL2:  ext_w = shl2_w;
            default: ext_w = sext_w;
        endcase
    end

    // ---------------------------------------------------------------
    // 2-entry FIFO state
    // ---------------------------------------------------------------
    logic [OUT_W-1:0] data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;

    logic push;
    logic pop;
    logic full;
    logic empty;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

    // ready looks only at stored state and the squash inputs, never at
    // out_ready, so no combinational path crosses the buffer
    assign bus.in_ready  = ~full & ~flush & ~Reset;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = data_q[rd_q];
    assign bus.out_tag   = tag_q[rd_q];
    assign bus.occupancy = cnt_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // slots are cleared too so the head reads zero after reset
            cnt_q     <= 2'd0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
        end else if (flush) begin
            // squash: drop contents, keep stale slot data
            cnt_q <= 2'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                data_q[wr_q] <= ext_w;
                tag_q[wr_q]  <= bus.in_tag;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Randomised and directed bench for ext_unit_pipe against a queue-based
// reference model of the extension rules and the 2-entry buffer.
module tb_ext_unit_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
    } ent_t;

    logic Clk;
    logic Reset;
    logic flush;

    ext_unit_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    ext_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   zhead = 1'b0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // extension computed arithmetically from the field's numeric value
    function automatic logic [OUT_W-1:0] ext_ref(input int mode,
                                                 input longint d);
        longint sx;
        longint r;
        logic [63:0] rv;
        sx = (d >= (longint'(1) << (IN_W - 1))) ? d - (longint'(1) << IN_W) : d;
        case (mode)
            0:       r = sx;
            1:       r = d;
            2:       r = d * (longint'(1) << (OUT_W - IN_W));
            default: r = sx * 4;
        endcase
        rv = r;
        return rv[OUT_W-1:0];
    endfunction

    task automatic step(input bit v, input int m, input int d, input int t,
                        input bit ordy, input bit fl, input bit rst);
        bit     exp_rdy;
        bit     push;
        bit     pop;
        ent_t   e;
        longint dv;
        @(negedge Clk);
        bus.in_valid  = v;
        bus.in_mode   = m[1:0];
        bus.in_data   = d[IN_W-1:0];
        bus.in_tag    = t[TAG_W-1:0];
        bus.out_ready = ordy;
        flush         = fl;
        Reset         = rst;
        #1;
        exp_rdy = (q.size() < 2) && !fl && !rst;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        push = v && exp_rdy;
        pop  = (q.size() != 0) && ordy;
        if (rst) begin
            q.delete();
            zhead = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                dv  = longint'(d) & ((longint'(1) << IN_W) - 1);
                e.d = ext_ref(m & 3, dv);
                e.t = t[TAG_W-1:0];
                q.push_back(e);
                zhead = 1'b0;
            end
        end
        @(posedge Clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
        if (q.size() != 0) begin
            chk("out_data", 64'(bus.out_data), 64'(q[0].d));
            chk("out_tag", 64'(bus.out_tag), 64'(q[0].t));
        end else if (zhead) begin
            chk("rst_data", 64'(bus.out_data), 64'd0);
            chk("rst_tag", 64'(bus.out_tag), 64'd0);
        end
    endtask

    logic [OUT_W-1:0] held_d;
    logic [TAG_W-1:0] held_t;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'd0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        Reset         = 1'b1;

        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);

        // mode checks with known constants
        step(1, 0, 'h8000, 1, 1, 0, 0);
        chk("sext_8000", 64'(bus.out_data), 64'h0000_0000_FFFF_8000);
        step(1, 1, 'h8000, 2, 1, 0, 0);
        chk("zext_8000", 64'(bus.out_data), 64'h0000_0000_0000_8000);
        step(1, 2, 'h1234, 3, 1, 0, 0);
        chk("upper_1234", 64'(bus.out_data), 64'h0000_0000_1234_0000);
        step(1, 3, 'hFFFF, 4, 1, 0, 0);
        chk("shl2_ffff", 64'(bus.out_data), 64'h0000_0000_FFFF_FFFC);
        step(1, 3, 'h7FFF, 5, 1, 0, 0);
        chk("shl2_7fff", 64'(bus.out_data), 64'h0000_0000_0001_FFFC);
        chk("shl2_tag", 64'(bus.out_tag), 64'd5);
        step(0, 0, 0, 0, 1, 0, 0);

        // back-pressure: third push held off
        step(1, 0, 'h11, 1, 0, 0, 0);
        step(1, 0, 'h22, 2, 0, 0, 0);
        chk("bp_full", 64'(bus.in_ready), 64'd0);
        step(1, 0, 'h33, 3, 0, 0, 0);
        step(1, 0, 'h33, 3, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 'h8000 + i * 'h111, i, 1, 0, 0);
            chk("stream_occ", 64'(bus.occupancy), 64'd1);
        end
        step(0, 0, 0, 0, 1, 0, 0);

        // stall hold
        step(1, 2, 'hBEEF, 7, 0, 0, 0);
        held_d = bus.out_data;
        held_t = bus.out_tag;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("hold_data", 64'(bus.out_data), 64'(held_d));
            chk("hold_tag", 64'(bus.out_tag), 64'(held_t));
        end

        // flush at occupancy 2 with a word offered
        step(1, 1, 'h0A0A, 8, 0, 0, 0);
        step(1, 1, 'h0B0B, 9, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // reset mid-stream
        step(1, 0, 'h1357, 10, 0, 0, 0);
        step(1, 0, 'h2468, 11, 0, 0, 1);
        chk("mid_rst_data", 64'(bus.out_data), 64'd0);
        step(1, 3, 'h8001, 12, 1, 0, 0);
        chk("post_rst", 64'(bus.out_data), 64'h0000_0000_FFFE_0004);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 4), int'($urandom),
                 int'($urandom), ($urandom % 3) != 0,
                 ($urandom % 20) == 0, ($urandom % 50) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
